dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU A, debug B) arbiter onto a single-port sync data memory; grants are combinational, read data returns 1 cycle after grant.
// Losers stall (a_stall) and must hold their request; B can lock ownership, and contested cycles alternate through a priority pointer.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          a_stall,
    output logic [7:0]    conflicts
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          a_rd_q, b_rd_q;
    logic [DW-1:0] a_rdata_q, b_rdata_q;
    logic [7:0]    conf_q, conf_d;
    logic          contested;

    assign contested = a_req & b_req;

    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        ptr_d   = ptr_q;
        state_d = state_q;
        if (!reset) begin
            if (state_q == ST_LOCKED) begin
                b_gnt = b_req;
            end else if (contested) begin
                a_gnt = ~ptr_q;
                b_gnt = ptr_q;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
            // Pointer names the loser of a contested cycle so it wins next time.
            if (contested) begin
                ptr_d = a_gnt;
            end
            case (state_q)
                ST_UNLOCKED: if (b_gnt && b_lock) state_d = ST_LOCKED;
                ST_LOCKED:   if ((b_gnt && !b_lock) || !b_req) state_d = ST_UNLOCKED;
                default:     state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_comb begin
        mem_we   = (a_gnt & a_we) | (b_gnt & b_we);
        mem_addr = addr_q;
        mem_din  = din_q;
        if (a_gnt) begin
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end else if (b_gnt) begin
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    assign a_stall  = a_req & ~a_gnt;
    assign a_rvalid = a_rd_q;
    assign b_rvalid = b_rd_q;
    // Memory output is only meaningful the cycle after a read grant; otherwise replay the captured value.
    assign a_rdata  = a_rd_q ? mem_dout : a_rdata_q;
    assign b_rdata  = b_rd_q ? mem_dout : b_rdata_q;
    assign conflicts = conf_q;

    always_comb begin
        conf_d = conf_q;
        if (contested && (conf_q != 8'hFF)) begin
            conf_d = conf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_UNLOCKED;
            ptr_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            a_rd_q    <= 1'b0;
            b_rd_q    <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            conf_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= mem_addr;
            din_q     <= mem_din;
            a_rd_q    <= a_gnt & ~a_we;
            b_rd_q    <= b_gnt & ~b_we;
            a_rdata_q <= a_rdata;
            b_rdata_q <= b_rdata;
            conf_q    <= conf_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter with a rule-level reference model and read-return scoreboard.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_we, b_req, b_we, b_lock;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, a_stall;
    logic [7:0] a_rdata, b_rdata, mem_addr, mem_din, mem_dout, conflicts;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .a_stall(a_stall), .conflicts(conflicts)
    );

    function automatic logic [7:0] init_val(int i);
        if (i == 16) return 8'h5A;
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Behavioural single-port synchronous RAM, 1-cycle read latency.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model state
    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;
    rd_t        qa[$];
    rd_t        qb[$];
    bit         m_ptr, m_lock;
    int         m_conf;
    logic [7:0] m_addr, m_din, last_a, last_b;
    logic [7:0] m_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = init_val(i);
            m_mem[i] = init_val(i);
        end
    end

    always @(negedge clk) begin : model
        bit ea, eb, con;
        logic [7:0] ex_addr, ex_din;
        if (reset) begin
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_conflicts", conflicts, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_din", mem_din, 0);
            m_ptr = 0; m_lock = 0; m_conf = 0; m_addr = 0; m_din = 0;
        end else begin
            con = a_req && b_req;
            if (m_lock) begin ea = 0; eb = b_req; end
            else if (con) begin ea = !m_ptr; eb = m_ptr; end
            else begin ea = a_req; eb = b_req; end
            ex_addr = ea ? a_addr : (eb ? b_addr : m_addr);
            ex_din  = ea ? a_wdata : (eb ? b_wdata : m_din);
            chk("a_gnt", a_gnt, 32'(ea));
            chk("b_gnt", b_gnt, 32'(eb));
            chk("a_stall", a_stall, 32'(a_req && !ea));
            chk("mem_we", mem_we, 32'((ea && a_we) || (eb && b_we)));
            chk("mem_addr", mem_addr, 32'(ex_addr));
            chk("mem_din", mem_din, 32'(ex_din));
            chk("conflicts", conflicts, 32'(m_conf));
            m_addr = ex_addr;
            m_din  = ex_din;
            if (con) begin
                m_ptr = ea;
                if (m_conf < 255) m_conf++;
            end
            if (ea && !a_we) qa.push_back('{m_mem[a_addr], cyc + 1});
            if (eb && !b_we) qb.push_back('{m_mem[b_addr], cyc + 1});
            if (ea && a_we) m_mem[a_addr] = a_wdata;
            if (eb && b_we) m_mem[b_addr] = b_wdata;
            if (!m_lock) m_lock = eb && b_lock;
            else if ((eb && !b_lock) || !b_req) m_lock = 0;
        end
    end

    always @(negedge clk) begin : monitor
        if (reset) begin
            qa.delete();
            qb.delete();
            last_a = 0;
            last_b = 0;
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
            chk("rst_a_rdata", a_rdata, 0);
            chk("rst_b_rdata", b_rdata, 0);
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                chk("a_rvalid", a_rvalid, 1);
                chk("a_rdata", a_rdata, 32'(qa[0].data));
                last_a = qa[0].data;
                void'(qa.pop_front());
            end else begin
                chk("a_rvalid_idle", a_rvalid, 0);
                chk("a_rdata_hold", a_rdata, 32'(last_a));
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                chk("b_rvalid", b_rvalid, 1);
                chk("b_rdata", b_rdata, 32'(qb[0].data));
                last_b = qb[0].data;
                void'(qb.pop_front());
            end else begin
                chk("b_rvalid_idle", b_rvalid, 0);
                chk("b_rdata_hold", b_rdata, 32'(last_b));
            end
        end
    end

    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                         input logic bl);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ra();
        return 8'($urandom_range(0, 15));
    endfunction

    function automatic logic [7:0] rd8();
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        reset = 1'b1;
        drive(1, 1, 8'h05, 8'h11, 1, 1, 8'h06, 8'h22, 1);
        repeat (3) tick();
        reset = 1'b0;

        // Lone CPU read of a known location.
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        #1 chk("solo_a_gnt", a_gnt, 1);
        tick();
        idle();
        chk("solo_a_rvalid", a_rvalid, 1);
        chk("solo_a_rdata", a_rdata, 8'h5A);
        chk("solo_b_rvalid", b_rvalid, 0);
        tick();

        // Six contested reads: first contested after reset goes to A, then alternate.
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, ra(), 8'h00, 1, 0, ra(), 8'h00, 0);
            if (i == 0) #1 chk("first_contest_a", a_gnt, 1);
            tick();
        end
        idle();
        #1 chk("conflicts_6", conflicts, 6);
        tick();

        // B writes, A reads the same address next cycle.
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3, 0);
        tick();
        drive(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        tick();
        idle();
        chk("wr_rd_rvalid", a_rvalid, 1);
        chk("wr_rd_data", a_rdata, 8'hC3);
        tick();

        // B takes the lock while A keeps requesting, then releases.
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, ra(), 8'h00, 1, 0, ra(), 8'h00, 1);
            tick();
        end
        drive(1, 0, ra(), 8'h00, 0, 0, 8'h00, 8'h00, 0);
        repeat (2) tick();
        idle();
        tick();

        // Long fully-contested run drives conflicts into saturation.
        for (int i = 0; i < 300; i++) begin
            drive(1, 1'($urandom_range(0, 1)), ra(), rd8(), 1, 1'($urandom_range(0, 1)), ra(), rd8(), 0);
            tick();
        end
        idle();
        #1 chk("conflicts_sat", conflicts, 8'hFF);
        tick();

        // Reset in the cycle after a read grant must swallow the read return.
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        tick();
        reset = 1'b1;
        idle();
        #1 chk("rst_kills_rvalid", a_rvalid, 0);
        tick();
        reset = 1'b0;

        // Reset while LOCKED returns to unlocked with ptr=0.
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h03, 8'h00, 1);
        repeat (2) tick();
        drive(1, 0, 8'h04, 8'h00, 1, 0, 8'h03, 8'h00, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 0, 8'h07, 8'h00, 1, 0, 8'h08, 8'h00, 0);
        #1;
        chk("post_rst_contest_a", a_gnt, 1);
        chk("post_rst_b_gnt", b_gnt, 0);
        chk("post_rst_conflicts", conflicts, 0);
        tick();

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ra(), rd8(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ra(), rd8(),
                  1'($urandom_range(0, 2) == 0));
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
